// File: rtl/mmult_seq_pkg.sv
// mmult_seq_pkg: definitions shared by the MMULT sequencer.
//   NTERM_W    - default width of the term count and of mwidth
//   REG_SEL_W  - width of the register-pair index
//   mmult_st_e - sequencer state encoding (IDLE=0, CLEAR=1, FETCH=2, DONE=3)
package mmult_seq_pkg;

    localparam int unsigned NTERM_W   = 4;
    localparam int unsigned REG_SEL_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StFetch = 2'd2,
        StDone  = 2'd3
    } mmult_st_e;

endpackage

// File: rtl/mmult_seq_if.sv
// mmult_seq_if: GPU-side and RAM-side signals of the MMULT sequencer.
//   master - the GPU/RAM side: drives go, control-register fields, mtxa_wr, mem_gnt
//   slave  - the sequencer: drives counter controls, RAM request, MAC enables, status
interface mmult_seq_if #(
    parameter int unsigned NTERM_W = mmult_seq_pkg::NTERM_W
) ();

    logic               mmult_go;
    logic [NTERM_W-1:0] mtxc_width;
    logic               mtxc_addw;
    logic               mtxa_wr;
    logic               mem_gnt;

    logic               cntld;
    logic               cnten;
    logic               maddw;
    logic [NTERM_W-1:0] mwidth;
    logic               mem_req;
    logic               acc_clr;
    logic               acc_en;
    logic [3:0]         reg_sel;
    logic               hi_half;
    logic               busy;
    logic               done;

    modport master (
        output mmult_go, mtxc_width, mtxc_addw, mtxa_wr, mem_gnt,
        input  cntld, cnten, maddw, mwidth, mem_req, acc_clr, acc_en,
               reg_sel, hi_half, busy, done
    );

    modport slave (
        input  mmult_go, mtxc_width, mtxc_addw, mtxa_wr, mem_gnt,
        output cntld, cnten, maddw, mwidth, mem_req, acc_clr, acc_en,
               reg_sel, hi_half, busy, done
    );

endinterface

// File: rtl/mmult_term_cnt.sv
// mmult_term_cnt: term counter for the MMULT sequencer.
//   clk, resetl - clock, asynchronous active-low reset
//   clr_i       - restart the count at 0 (takes priority over inc_i)
//   inc_i       - advance to the next term
//   mwidth_i    - latched number of terms
//   k_o         - current term index
//   last_o      - current term is the final one (k == mwidth-1)
module mmult_term_cnt #(
    parameter int unsigned Width = mmult_seq_pkg::NTERM_W
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [Width-1:0] mwidth_i,
    output logic [Width-1:0] k_o,
    output logic             last_o
);

    logic [Width-1:0] k_q, k_d;

    always_comb begin
        k_d = k_q;
        if (clr_i) begin
            k_d = '0;
        end else if (inc_i) begin
            k_d = k_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    assign k_o    = k_q;
    // Width 0 never reaches FETCH, so the wrap of mwidth-1 is harmless.
    assign last_o = (k_q == (mwidth_i - Width'(1)));

endmodule

// File: rtl/mmult_seq.sv
// mmult_seq: sequencer for the MMULT systolic matrix-multiply instruction.
//   clk, resetl - clock, asynchronous active-low reset
//   bus (slave) - go/width/addw/mtxa_wr/mem_gnt in; address counter controls
//                 (cntld, cnten, maddw, mwidth), mem_req, acc_clr, acc_en,
//                 reg_sel, hi_half, busy, done out
module mmult_seq #(
    parameter int unsigned NTERM_W = mmult_seq_pkg::NTERM_W
) (
    input  logic        clk,
    input  logic        resetl,
    mmult_seq_if.slave  bus
);

    import mmult_seq_pkg::*;

    mmult_st_e          st_q, st_d;
    logic [NTERM_W-1:0] mwidth_q, mwidth_d;
    logic               maddw_q, maddw_d;
    logic [NTERM_W-1:0] k;
    logic               last;
    logic               go_accept;

    logic               busy;
    logic               fetch;
    logic               cntld;
    logic               cnten;
    logic               acc_clr;
    logic               acc_en;
    logic               mem_req;
    logic [3:0]         reg_sel;
    logic               hi_half;
    logic               done;

    assign go_accept = (st_q == StIdle) && bus.mmult_go;

    // State register
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            st_q <= StIdle;
        end else begin
            st_q <= st_d;
        end
    end

    // Next-state logic
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle: begin
                if (bus.mmult_go) begin
                    // A zero-term product skips the RAM entirely.
                    st_d = (bus.mtxc_width == '0) ? StDone : StClear;
                end
            end
            StClear: st_d = StFetch;
            StFetch: begin
                if (bus.mem_gnt && last) begin
                    st_d = StDone;
                end
            end
            StDone:  st_d = StIdle;
            default: st_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (st_q != StIdle);
        fetch   = (st_q == StFetch);
        // Address data is only on the GPU bus during the strobe, hence combinational.
        cntld   = bus.mtxa_wr && !busy;
        acc_clr = (st_q == StClear);
        mem_req = fetch;
        cnten   = fetch && bus.mem_gnt;
        acc_en  = fetch && bus.mem_gnt;
        reg_sel = '0;
        hi_half = 1'b0;
        if (fetch) begin
            // Term k comes from register pair k/2, low half first.
            reg_sel = 4'(k >> 1);
            hi_half = k[0];
        end
        done    = (st_q == StDone);
    end

    // Width and column mode persist between instructions for the address counter.
    always_comb begin
        mwidth_d = mwidth_q;
        maddw_d  = maddw_q;
        if (go_accept) begin
            mwidth_d = bus.mtxc_width;
            maddw_d  = bus.mtxc_addw;
        end
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            mwidth_q <= '0;
            maddw_q  <= 1'b0;
        end else begin
            mwidth_q <= mwidth_d;
            maddw_q  <= maddw_d;
        end
    end

    mmult_term_cnt #(
        .Width (NTERM_W)
    ) u_term_cnt (
        .clk      (clk),
        .resetl   (resetl),
        .clr_i    (go_accept),
        .inc_i    (cnten),
        .mwidth_i (mwidth_q),
        .k_o      (k),
        .last_o   (last)
    );

    assign bus.cntld   = cntld;
    assign bus.cnten   = cnten;
    assign bus.maddw   = maddw_q;
    assign bus.mwidth  = mwidth_q;
    assign bus.mem_req = mem_req;
    assign bus.acc_clr = acc_clr;
    assign bus.acc_en  = acc_en;
    assign bus.reg_sel = reg_sel;
    assign bus.hi_half = hi_half;
    assign bus.busy    = busy;
    assign bus.done    = done;

endmodule
